// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scanner for the stopwatch count.
// Once per scan frame the binary count is converted to BCD by a sequential double-dabble engine.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZ_BLANK = 1'b1,
  parameter int unsigned DP_DIGIT = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        conv_busy
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LATCH
  } state_t;

  // Scan timing
  logic [PW-1:0] prescaler;
  logic [1:0]    digit_sel;
  logic          tick;
  logic          frame_start;

  assign tick        = (prescaler == PS_MAX);
  assign frame_start = tick && (digit_sel == 2'd3);

  always_ff @(posedge CLK) begin
    if (reset) begin
      prescaler <= '0;
      digit_sel <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) digit_sel <= digit_sel + 2'd1;
    end
  end

  // Conversion engine
  state_t      state, state_n;
  logic        init_pend, init_pend_n;
  logic [15:0] sh_bcd, sh_bcd_n;
  logic [13:0] sh_bin, sh_bin_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [15:0] bcd_disp, bcd_disp_n;
  logic [13:0] sat;
  logic [15:0] adj;

  assign sat = (value > 14'd9999) ? 14'd9999 : value;

  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj = dd_adjust(sh_bcd);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= S_IDLE;
      init_pend <= 1'b1;
      sh_bcd    <= '0;
      sh_bin    <= '0;
      bit_cnt   <= '0;
      bcd_disp  <= '0;
    end else begin
      state     <= state_n;
      init_pend <= init_pend_n;
      sh_bcd    <= sh_bcd_n;
      sh_bin    <= sh_bin_n;
      bit_cnt   <= bit_cnt_n;
      bcd_disp  <= bcd_disp_n;
    end
  end

  always_comb begin
    state_n     = state;
    init_pend_n = init_pend;
    sh_bcd_n    = sh_bcd;
    sh_bin_n    = sh_bin;
    bit_cnt_n   = bit_cnt;
    bcd_disp_n  = bcd_disp;
    conv_busy   = 1'b0;
    case (state)
      S_IDLE: begin
        // init_pend forces one conversion right after reset so the display is valid before the first frame boundary
        if (frame_start || init_pend) begin
          state_n     = S_CONV;
          init_pend_n = 1'b0;
          sh_bcd_n    = '0;
          sh_bin_n    = sat;
          bit_cnt_n   = '0;
        end
      end
      S_CONV: begin
        conv_busy              = 1'b1;
        {sh_bcd_n, sh_bin_n}   = {adj[14:0], sh_bin, 1'b0};
        bit_cnt_n              = bit_cnt + 4'd1;
        if (bit_cnt == 4'd13) state_n = S_LATCH;
      end
      S_LATCH: begin
        conv_busy  = 1'b1;
        bcd_disp_n = sh_bcd;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output stage
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [3:0] nib;
  logic [3:0] nib_zero;
  logic [3:0] upper_zero;
  logic       digit_off;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  always_comb begin
    nib_zero = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nib_zero[i] = (bcd_disp[4*i +: 4] == 4'd0);
    end
    // upper_zero[k]: nibbles k..3 are all zero
    upper_zero[3] = nib_zero[3];
    upper_zero[2] = nib_zero[2] & upper_zero[3];
    upper_zero[1] = nib_zero[1] & upper_zero[2];
    upper_zero[0] = nib_zero[0] & upper_zero[1];

    nib       = bcd_disp[{digit_sel, 2'b00} +: 4];
    digit_off = blank ||
                (LZ_BLANK && (32'(digit_sel) > DP_DIGIT) && upper_zero[digit_sel]);
    an_n      = digit_off ? '1 : ~(4'b0001 << digit_sel);
    seg_n     = digit_off ? '1 : seg_decode(nib);
    dp_n      = !((32'(digit_sel) == DP_DIGIT) && !digit_off);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

endmodule
